// File: rtl/conv_pkg.sv
// Shared types and default widths for the 2x2 convolution window scheduler.
package conv_pkg;
  localparam int DW    = 8;
  localparam int ACC_W = 2*DW + 2;

  typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_e;
endpackage

// File: rtl/conv2x2_mac.sv
// Four-term unsigned dot product with a registered full-precision result.
module conv2x2_mac #(
  parameter int DW    = conv_pkg::DW,
  parameter int ACC_W = 2*DW + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [3:0][DW-1:0]    pix_i,
  input  logic [3:0][DW-1:0]    w_i,
  output logic [ACC_W-1:0]      acc_o
);
  logic [ACC_W-1:0] acc_q, acc_d;

  // Operands are widened before multiplying so the sum of four products never wraps.
  always_comb begin
    acc_d = '0;
    for (int i = 0; i < 4; i++)
      acc_d = acc_d + ACC_W'(pix_i[i]) * ACC_W'(w_i[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/conv_window_sched.sv
// Loads a weight quad and an image, then streams every 2x2 window dot product in raster order.
module conv_window_sched #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4,
  parameter int DW    = conv_pkg::DW,
  localparam int ACC_W = 2*DW + 2,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_is_weight,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX);

  conv_pkg::state_e state_q, state_d;
  logic [1:0]                 wptr_q, wptr_d;
  logic [PW-1:0]              pptr_q, pptr_d;
  logic [RW-1:0]              r_q, r_d;
  logic [CW-1:0]              c_q, c_d;
  logic [3:0][DW-1:0]         w_q, w_d;
  logic [NPIX-1:0][DW-1:0]    pix_q, pix_d;
  logic [3:0][DW-1:0]         win;
  logic [PW-1:0]              base;
  logic                       mac_en, last_pos;

  // Window top-left in the row-major buffer; neighbours are +1, +IMG_W, +IMG_W+1.
  always_comb begin
    base   = PW'(r_q) * PW'(IMG_W) + PW'(c_q);
    win[0] = pix_q[base];
    win[1] = pix_q[base + PW'(1)];
    win[2] = pix_q[base + PW'(IMG_W)];
    win[3] = pix_q[base + PW'(IMG_W + 1)];
  end

  assign last_pos = (r_q == RW'(IMG_H - 2)) && (c_q == CW'(IMG_W - 2));

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    pptr_d    = pptr_q;
    r_d       = r_q;
    c_d       = c_q;
    w_d       = w_q;
    pix_d     = pix_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      conv_pkg::IDLE: begin
        busy     = 1'b0;
        in_ready = !start;
        if (start) begin
          state_d = conv_pkg::RUN;
          wptr_d  = '0;
          pptr_d  = '0;
          r_d     = '0;
          c_d     = '0;
        end else if (in_valid) begin
          if (in_is_weight) begin
            w_d[wptr_q] = in_data;
            wptr_d      = wptr_q + 2'd1;
          end else begin
            pix_d[pptr_q] = in_data;
            pptr_d        = (pptr_q == PW'(NPIX - 1)) ? '0 : pptr_q + PW'(1);
          end
        end
      end
      conv_pkg::RUN: begin
        mac_en  = 1'b1;
        state_d = conv_pkg::EMIT;
      end
      conv_pkg::EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_pos) begin
            state_d = conv_pkg::DONE;
          end else begin
            state_d = conv_pkg::RUN;
            if (c_q == CW'(IMG_W - 2)) begin
              c_d = '0;
              r_d = r_q + RW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      conv_pkg::DONE: begin
        done    = 1'b1;
        state_d = conv_pkg::IDLE;
      end
      default: state_d = conv_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= conv_pkg::IDLE;
      wptr_q  <= '0;
      pptr_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      w_q     <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      pptr_q  <= pptr_d;
      r_q     <= r_d;
      c_q     <= c_d;
      w_q     <= w_d;
      pix_q   <= pix_d;
    end
  end

  conv2x2_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (mac_en),
    .pix_i (win),
    .w_i   (w_q),
    .acc_o (out_data)
  );

  assign out_row = r_q;
  assign out_col = c_q;
endmodule
